// File: rtl/gpr_alu_sequencer.sv
// gpr_alu_sequencer: single-issue operand sequencer and ALU in front of the
// 8x8 general purpose register file. It reads rs1 and then rs2 through the
// shared register-file port, computes the result, writes it back to rd, and
// pulses done.
module gpr_alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int RBITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [RBITS-1:0] rd,
  input  logic [RBITS-1:0] rs1,
  input  logic [RBITS-1:0] rs2,
  input  logic [WIDTH-1:0] readFromReg,
  output logic             read_en,
  output logic             write_en,
  output logic [RBITS-1:0] reg_num,
  output logic [WIDTH-1:0] writeToReg,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_LAT_B,
    S_EXEC,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_INC = 3'b110,
    OP_NOT = 3'b111
  } op_t;

  state_t           r_state;
  op_t              r_op;
  logic [RBITS-1:0] r_rd;
  logic [RBITS-1:0] r_rs2;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_done;
  logic             r_read_en;
  logic             r_write_en;
  logic [RBITS-1:0] r_reg_num;
  logic [WIDTH-1:0] r_wdata;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;

  // ALU: one extra bit on the sum carries the carry-out / borrow
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_sum   = {1'b0, r_opa} + {1'b0, r_opb};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_sum   = {1'b0, r_opa} - {1'b0, r_opb};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_AND: w_res = r_opa & r_opb;
      OP_OR:  w_res = r_opa | r_opb;
      OP_XOR: w_res = r_opa ^ r_opb;
      OP_MOV: w_res = r_opa;
      OP_INC: begin
        w_sum   = {1'b0, r_opa} + {{WIDTH{1'b0}}, 1'b1};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_NOT: w_res = ~r_opa;
      default: begin
        w_res   = '0;
        w_carry = 1'b0;
      end
    endcase
  end

  // Sequencer FSM; port strobes are registered one state ahead so they
  // appear exactly during the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_ADD;
      r_rd       <= '0;
      r_rs2      <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_done     <= 1'b0;
      r_read_en  <= 1'b0;
      r_write_en <= 1'b0;
      r_reg_num  <= '0;
      r_wdata    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_read_en  <= 1'b0;
      r_write_en <= 1'b0;
      r_reg_num  <= '0;
      r_wdata    <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // rs1 is only needed for the first read, issued right here
            r_op      <= op_t'(opcode);
            r_rd      <= rd;
            r_rs2     <= rs2;
            r_read_en <= 1'b1;
            r_reg_num <= rs1;
            r_state   <= S_RD_A;
          end
        end
        S_RD_A: begin
          r_read_en <= 1'b1;
          r_reg_num <= r_rs2;
          r_state   <= S_RD_B;
        end
        S_RD_B: begin
          r_opa   <= readFromReg;
          r_state <= S_LAT_B;
        end
        S_LAT_B: begin
          r_opb   <= readFromReg;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result   <= w_res;
          r_zero     <= (w_res == '0);
          r_carry    <= w_carry;
          r_write_en <= 1'b1;
          r_reg_num  <= r_rd;
          r_wdata    <= w_res;
          r_state    <= S_WB;
        end
        S_WB: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_en    = r_read_en;
  assign write_en   = r_write_en;
  assign reg_num    = r_reg_num;
  assign writeToReg = r_wdata;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign result     = r_result;
  assign zero       = r_zero;
  assign carry      = r_carry;

endmodule

// File: tb/tb_gpr_alu_sequencer.sv
// Bench for gpr_alu_sequencer: an 8x8 register file model serves the DUT,
// while a command-level model predicts every output on every cycle.
module tb_gpr_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = '0;
  logic [2:0] rd = '0;
  logic [2:0] rs1 = '0;
  logic [2:0] rs2 = '0;
  logic [7:0] readFromReg = '0;
  logic       read_en, write_en, busy, done, zero, carry;
  logic [2:0] reg_num;
  logic [7:0] writeToReg, result;

  gpr_alu_sequencer #(.WIDTH(8), .RBITS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .readFromReg(readFromReg),
    .read_en(read_en), .write_en(write_en), .reg_num(reg_num),
    .writeToReg(writeToReg), .busy(busy), .done(done),
    .result(result), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // register file seen by the DUT, with a backdoor preload port
  logic [7:0] rf [8];
  logic       pl_en = 1'b0;
  logic [2:0] pl_idx = '0;
  logic [7:0] pl_val = '0;

  always @(posedge clk) begin
    if (pl_en) rf[pl_idx] <= pl_val;
    if (read_en === 1'b1) readFromReg <= rf[reg_num];
    if (write_en === 1'b1) rf[reg_num] <= writeToReg;
  end

  // command-level reference model
  int m_rf [8];
  int m_ph = -1;        // -1 idle, 0..4 cycles of an active command, 5 done cycle
  bit m_on = 1'b0;
  int m_op, m_rd, m_rs1, m_rs2;
  int m_res = 0, m_z = 0, m_c = 0;

  function automatic void alu(input int op, input int a, input int b,
                              output int r, output int c);
    c = 0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a;
      6: begin r = (a + 1) % 256; c = (a == 255) ? 1 : 0; end
      default: r = 255 - a;
    endcase
  endfunction

  always @(posedge clk) begin
    if (pl_en) m_rf[pl_idx] = int'(pl_val);
    if (reset) begin
      m_on = 1'b1; m_ph = -1; m_res = 0; m_z = 0; m_c = 0;
    end else if (m_ph == -1 || m_ph == 5) begin
      if (start) begin
        m_op = int'(opcode); m_rd = int'(rd); m_rs1 = int'(rs1); m_rs2 = int'(rs2);
        m_ph = 0;
      end else begin
        m_ph = -1;
      end
    end else begin
      m_ph++;
      if (m_ph == 4) begin
        alu(m_op, m_rf[m_rs1], m_rf[m_rs2], m_res, m_c);
        m_z = (m_res == 0) ? 1 : 0;
      end
      if (m_ph == 5) m_rf[m_rd] = m_res;
    end
  end

  // per-cycle comparison of every output against the model
  always @(posedge clk) begin
    #1;
    if (m_on) begin
      chk("busy", 32'(busy), 32'(m_ph >= 0 && m_ph <= 4));
      chk("done", 32'(done), 32'(m_ph == 5));
      chk("read_en", 32'(read_en), 32'(m_ph == 0 || m_ph == 1));
      chk("write_en", 32'(write_en), 32'(m_ph == 4));
      chk("reg_num", 32'(reg_num),
          32'((m_ph == 0) ? m_rs1 : (m_ph == 1) ? m_rs2 : (m_ph == 4) ? m_rd : 0));
      chk("writeToReg", 32'(writeToReg), 32'((m_ph == 4) ? m_res : 0));
      chk("result", 32'(result), 32'(m_res));
      chk("zero", 32'(zero), 32'(m_z));
      chk("carry", 32'(carry), 32'(m_c));
      chk("rw_exclusive", 32'(read_en & write_en), 32'(0));
      if (m_ph == 5) chk("rf_dest", 32'(rf[m_rd]), 32'(m_rf[m_rd]));
      if (done === 1'b1) n_done++;
    end
  end

  // all stimulus tasks are entered and left at a negedge
  task automatic preload(input int idx, input int val);
    pl_en = 1'b1; pl_idx = 3'(idx); pl_val = 8'(val);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    chk("done_timeout", 32'(seen), 32'(1));
  endtask

  task automatic issue(input int op, input int d, input int a, input int b);
    start = 1'b1; opcode = 3'(op); rd = 3'(d); rs1 = 3'(a); rs2 = 3'(b);
    @(negedge clk);
    start = 1'b0; opcode = 3'($urandom); rd = 3'($urandom);
    rs1 = 3'($urandom); rs2 = 3'($urandom);
    wait_done();
  endtask

  int d0;

  initial begin
    reset = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_read_en", 32'(read_en), 32'(0));
    chk("rst_write_en", 32'(write_en), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_zero", 32'(zero), 32'(0));
    chk("rst_carry", 32'(carry), 32'(0));
    start = 1'b0;
    for (int i = 0; i < 8; i++) preload(i, int'($urandom_range(0, 255)));
    reset = 1'b0;
    @(negedge clk);

    // ADD with carry-out
    preload(1, 'hF0); preload(2, 'h20);
    issue(0, 3, 1, 2);
    chk("add_r3", 32'(rf[3]), 32'h10);
    chk("add_result", 32'(result), 32'h10);
    chk("add_carry", 32'(carry), 32'(1));
    chk("add_zero", 32'(zero), 32'(0));

    // SUB equal operands, then borrow
    preload(4, 'h05); preload(5, 'h05);
    issue(1, 6, 4, 5);
    chk("sub_r6", 32'(rf[6]), 32'h00);
    chk("sub_zero", 32'(zero), 32'(1));
    chk("sub_carry", 32'(carry), 32'(0));
    preload(5, 'h06);
    issue(1, 6, 4, 5);
    chk("subb_r6", 32'(rf[6]), 32'hFF);
    chk("subb_carry", 32'(carry), 32'(1));

    // INC with every field aliased to R7
    preload(7, 'h7F);
    issue(6, 7, 7, 7);
    chk("inc_r7", 32'(rf[7]), 32'h80);
    chk("inc_carry", 32'(carry), 32'(0));
    preload(7, 'hFF);
    issue(6, 7, 7, 7);
    chk("incw_r7", 32'(rf[7]), 32'h00);
    chk("incw_zero", 32'(zero), 32'(1));
    chk("incw_carry", 32'(carry), 32'(1));

    // start pulse with new fields while busy must be ignored
    preload(1, 'hCC); preload(2, 'hAA); preload(5, 'h3C);
    d0 = n_done;
    start = 1'b1; opcode = 3'd2; rd = 3'd0; rs1 = 3'd1; rs2 = 3'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; opcode = 3'd3; rd = 3'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("and_r0", 32'(rf[0]), 32'h88);
    chk("and_r5_kept", 32'(rf[5]), 32'h3C);
    repeat (8) @(negedge clk);
    chk("and_one_done", 32'(n_done - d0), 32'(1));

    // reset during EXEC aborts the XOR
    preload(2, 'h5A); preload(3, 'h0F); preload(1, 'h77);
    d0 = n_done;
    start = 1'b1; opcode = 3'd4; rd = 3'd1; rs1 = 3'd2; rs2 = 3'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_result", 32'(result), 32'(0));
    repeat (8) @(negedge clk);
    chk("abort_r1", 32'(rf[1]), 32'h77);
    chk("abort_no_done", 32'(n_done - d0), 32'(0));

    // random traffic including held start and occasional reset
    for (int i = 0; i < 600; i++) begin
      start  = 1'($urandom_range(0, 3) != 0);
      opcode = 3'($urandom); rd = 3'($urandom);
      rs1    = 3'($urandom); rs2 = 3'($urandom);
      reset  = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);
    chk("final_idle", 32'(busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_alu_sequencer.md
Name: gpr_alu_sequencer

Overview:
- Single-issue operand sequencer and ALU sitting directly in front of the 8x8 general purpose register file.
- Accepts one register-to-register command (op, rd, rs1, rs2).
- Uses the register file's single shared port to read rs1, then rs2. Computes the result, writes it back to rd, then reports completion.
- Owns all read_en/write_en/reg_num/writeToReg traffic to the register file. It never asserts read and write together, because the register file gives read priority.

Parameters:
- WIDTH, 8, data width; must equal the register file word width.
- RBITS, 3, register index width (2^RBITS registers).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command request; sampled only in IDLE.
- opcode  input  3  operation select (see Behaviour).
- rd  input  RBITS  destination register.
- rs1  input  RBITS  source A register.
- rs2  input  RBITS  source B register.
- readFromReg  input  WIDTH  registered read data from the register file; valid the cycle after read_en.
- read_en  output  1  register file read strobe.
- write_en  output  1  register file write strobe.
- reg_num  output  RBITS  register file index.
- writeToReg  output  WIDTH  register file write data.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  last computed result; held until the next EXEC.
- zero  output  1  result == 0; updated in EXEC.
- carry  output  1  carry/borrow of last operation; updated in EXEC.

Behaviour:
- Reset (synchronous): state=IDLE; done, result, zero, carry, and latched opA/opB/command fields all cleared to 0.
  - read_en=0, write_en=0, reg_num=0, writeToReg=0 during and after reset.
  - Reset mid-command aborts the command: no write_en is issued and no done pulse.
- States: IDLE -> RD_A -> RD_B -> LAT_B -> EXEC -> WB -> IDLE.
  - Every state except IDLE is unconditional and lasts 1 cycle.
- IDLE: busy=0.
  - If start=1 at the edge, latch opcode/rd/rs1/rs2 and go to RD_A.
  - The latched fields are used for the whole command; input changes while busy are ignored.
  - start while busy is ignored. Commands are not queued.
- RD_A: read_en=1, reg_num=rs1.
- RD_B: read_en=1, reg_num=rs2. opA <= readFromReg at the end of this cycle.
- LAT_B: read_en=0. opB <= readFromReg at the end of this cycle.
- EXEC: result, zero and carry registered at the end of this cycle.
- WB: write_en=1, reg_num=rd, writeToReg=result.
  - The write lands at the end of this cycle; next state is IDLE.
  - done=1 for exactly the one cycle after WB. busy=0 in that cycle.
- Outputs read_en/write_en/reg_num/writeToReg are a Moore decode of state. In IDLE, LAT_B and EXEC they are 0/0/0/0.
- Latency: start sampled at edge E0 -> write at edge E5 -> done high in cycle E5..E6.
  - Back-to-back: start may be held high; the next command is accepted at the edge ending the done cycle. Minimum issue interval is 6 cycles.
- Opcodes; all arithmetic is WIDTH bits, wrap-around modulo 2^WIDTH:
  - 000 ADD: A+B; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 001 SUB: A-B; carry = 1 iff A<B (borrow).
  - 010 AND: carry=0.
  - 011 OR: carry=0.
  - 100 XOR: carry=0.
  - 101 MOV: result=A; carry=0.
  - 110 INC: result=A+1; carry=1 iff A==all-ones.
  - 111 NOT: result=~A; carry=0.
- Both operands are always read, even for MOV/INC/NOT, so timing is uniform.
- Aliasing: rs1==rs2, and rd equal to either source, are legal. Reads complete before the write, so the old values are used.

Test Plan:
- Reset then idle: assert reset 2 cycles with start=1 -> busy=0, done=0, read_en=0, write_en=0, result=0, zero=0, carry=0.
- ADD with carry: preload R1=0xF0, R2=0x20; start op=000 rd=3 rs1=1 rs2=2.
  - Required read sequence: read_en with reg_num 1, then 2.
  - Write with reg_num=3 and writeToReg=0x10 exactly 5 edges after start.
  - carry=1, zero=0, done pulse 1 cycle; R3=0x10.
- SUB borrow/zero: R4=0x05, R5=0x05, op=001 rd=6 -> R6=0x00, zero=1, carry=0. Then R5=0x06 -> R6=0xFF, carry=1.
- Aliasing: R7=0x7F, op=110 rd=7 rs1=7 rs2=7 -> R7=0x80, carry=0. Then R7=0xFF, INC -> R7=0x00, zero=1, carry=1.
- Busy protection: issue AND (R1=0xCC, R2=0xAA, rd=0); pulse start with op=011 and change rd during RD_B.
  - Only the AND executes: R0=0x88, one done pulse.
  - read_en and write_en are never high in the same cycle.
- Reset mid-op: start XOR, assert reset during EXEC -> no write_en, destination unchanged, state IDLE, result=0.
